// File: rtl/booth_mult_8bit.sv
// Sequential signed 8x8 radix-2 Booth multiplier, one Booth step per clock.
// The add/subtract path reuses the ripple adder_8bit plus a fulladder for bit 8.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[8];
endmodule

// state | meaning
// IDLE  | waiting for start
// CALC  | one Booth iteration per cycle, 8 in total
// DONE  | product valid, one-cycle done pulse; start here relaunches
module booth_mult_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  m;
  logic [8:0]  acc;
  logic [7:0]  q;
  logic        q_1;
  logic [3:0]  cnt;

  logic        sub, addsub;
  logic [7:0]  sum_lo;
  logic        carry_lo, sum_hi, carry_unused;
  logic [8:0]  s;
  logic [8:0]  acc_next;
  logic [7:0]  q_next;
  logic        load, last;

  assign addsub = q[0] ^ q_1;
  assign sub    = q[0] & ~q_1;

  adder_8bit u_add (
    .a    (acc[7:0]),
    .b    (m[7:0] ^ {8{sub}}),
    .cin  (sub),
    .sum  (sum_lo),
    .cout (carry_lo)
  );

  // bit 8 keeps the -128 subtraction from overflowing; its carry is dropped
  fulladder u_fa8 (
    .a    (acc[8]),
    .b    (m[8] ^ sub),
    .cin  (carry_lo),
    .s    (sum_hi),
    .cout (carry_unused)
  );

  assign s        = addsub ? {sum_hi, sum_lo} : acc;
  assign acc_next = {s[8], s[8:1]};
  assign q_next   = {s[0], q[7:1]};

  assign load = start && (state_q == IDLE || state_q == DONE);
  assign last = (state_q == CALC) && (cnt == 4'd7);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == 4'd7) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      m   <= {a[7], a};
      acc <= '0;
      q   <= b;
      q_1 <= 1'b0;
      cnt <= '0;
    end else if (state_q == CALC) begin
      acc <= acc_next;
      q   <= q_next;
      q_1 <= q[0];
      cnt <= cnt + 4'd1;
      if (last) product <= {acc_next[7:0], q_next};
    end
  end
endmodule
